adrv9001_tdd_ctrl: RTL and testbench

Frame-based TDD scheduler that sequences the ADRV9001 Rx and Tx channel datapaths. It generates the per-channel `tdd_en` levels from a programmable frame period and per-channel on/off offsets. It repeats for a programmed number of frames or runs until stopped. It sits in the `dclk_div` domain alongside the channel blocks, and its enables drive the channel `tdd_en` inputs.

---
 rtl/adrv9001_tdd_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_adrv9001_tdd_ctrl.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/adrv9001_tdd_ctrl.sv
// Frame-based TDD scheduler: drives the Rx/Tx channel tdd_en levels from a shadowed
// frame period and per-channel on/off offsets, for N frames or until stopped.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | waiting for start; configuration checked when start is seen
// RUN      | frames running; stop or final frame end leaves this state
// STOPPING | stop accepted; finishing the current frame, then back to IDLE
module adrv9001_tdd_ctrl #(
    parameter int CNT_WIDTH = 32,
    parameter int FRM_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 start,
    input  logic                 stop,
    input  logic [CNT_WIDTH-1:0] frame_len,
    input  logic [CNT_WIDTH-1:0] rx_on,
    input  logic [CNT_WIDTH-1:0] rx_off,
    input  logic [CNT_WIDTH-1:0] tx_on,
    input  logic [CNT_WIDTH-1:0] tx_off,
    input  logic [FRM_WIDTH-1:0] num_frames,
    output logic                 rx_tdd_en,
    output logic                 tx_tdd_en,
    output logic                 frame_strobe,
    output logic [FRM_WIDTH-1:0] frame_cnt,
    output logic                 busy,
    output logic                 done,
    output logic                 cfg_err
);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] RUN      = 2'd1;
    localparam logic [1:0] STOPPING = 2'd2;

    logic [1:0]           state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0] frame_len_q, frame_len_d;
    logic [CNT_WIDTH-1:0] rx_on_q, rx_on_d;
    logic [CNT_WIDTH-1:0] rx_off_q, rx_off_d;
    logic [CNT_WIDTH-1:0] tx_on_q, tx_on_d;
    logic [CNT_WIDTH-1:0] tx_off_q, tx_off_d;
    logic [FRM_WIDTH-1:0] num_frames_q, num_frames_d;
    logic [FRM_WIDTH-1:0] frame_cnt_q, frame_cnt_d;
    logic                 rx_en_q, rx_en_d;
    logic                 tx_en_q, tx_en_d;
    logic                 strobe_q, strobe_d;
    logic                 done_q, done_d;
    logic                 cfg_err_q, cfg_err_d;

    logic                 cfg_ok;
    logic                 wrap;
    logic                 last_frame;
    logic                 active;
    logic [FRM_WIDTH-1:0] frame_cnt_inc;

    // Validity is judged on the same values being captured into the shadows.
    always_comb begin
        cfg_ok = 1'b1;
        if (frame_len < CNT_WIDTH'(2))
            cfg_ok = 1'b0;
        if ((rx_on > rx_off) || (rx_off > frame_len))
            cfg_ok = 1'b0;
        if ((tx_on > tx_off) || (tx_off > frame_len))
            cfg_ok = 1'b0;
        if ((rx_on < rx_off) && (tx_on < tx_off) && (rx_on < tx_off) && (tx_on < rx_off))
            cfg_ok = 1'b0;
    end

    always_comb begin
        wrap          = (cnt_q == (frame_len_q - CNT_WIDTH'(1)));
        frame_cnt_inc = (frame_cnt_q == {FRM_WIDTH{1'b1}}) ? frame_cnt_q
                                                           : frame_cnt_q + FRM_WIDTH'(1);
        last_frame    = (num_frames_q != '0) && (frame_cnt_inc == num_frames_q);
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        frame_len_d  = frame_len_q;
        rx_on_d      = rx_on_q;
        rx_off_d     = rx_off_q;
        tx_on_d      = tx_on_q;
        tx_off_d     = tx_off_q;
        num_frames_d = num_frames_q;
        frame_cnt_d  = frame_cnt_q;
        cfg_err_d    = cfg_err_q;
        done_d       = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (start) begin
                    frame_len_d  = frame_len;
                    rx_on_d      = rx_on;
                    rx_off_d     = rx_off;
                    tx_on_d      = tx_on;
                    tx_off_d     = tx_off;
                    num_frames_d = num_frames;
                    if (cfg_ok) begin
                        cfg_err_d   = 1'b0;
                        frame_cnt_d = '0;
                        state_d     = RUN;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end
            RUN: begin
                cnt_d = wrap ? '0 : cnt_q + CNT_WIDTH'(1);
                if (wrap) begin
                    frame_cnt_d = frame_cnt_inc;
                    if (last_frame) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else if (stop) begin
                        state_d = STOPPING;
                    end
                end else if (stop) begin
                    state_d = STOPPING;
                end
            end
            STOPPING: begin
                cnt_d = wrap ? '0 : cnt_q + CNT_WIDTH'(1);
                if (wrap) begin
                    frame_cnt_d = frame_cnt_inc;
                    state_d     = IDLE;
                    done_d      = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Enables follow cnt by one stage and are forced low on the edge that leaves the run.
    always_comb begin
        active   = (state_q != IDLE) && (state_d != IDLE);
        strobe_d = active && (cnt_q == '0);
        rx_en_d  = active && (rx_on_q <= cnt_q) && (cnt_q < rx_off_q);
        tx_en_d  = active && (tx_on_q <= cnt_q) && (cnt_q < tx_off_q);
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            frame_len_q  <= '0;
            rx_on_q      <= '0;
            rx_off_q     <= '0;
            tx_on_q      <= '0;
            tx_off_q     <= '0;
            num_frames_q <= '0;
            frame_cnt_q  <= '0;
            rx_en_q      <= 1'b0;
            tx_en_q      <= 1'b0;
            strobe_q     <= 1'b0;
            done_q       <= 1'b0;
            cfg_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            frame_len_q  <= frame_len_d;
            rx_on_q      <= rx_on_d;
            rx_off_q     <= rx_off_d;
            tx_on_q      <= tx_on_d;
            tx_off_q     <= tx_off_d;
            num_frames_q <= num_frames_d;
            frame_cnt_q  <= frame_cnt_d;
            rx_en_q      <= rx_en_d;
            tx_en_q      <= tx_en_d;
            strobe_q     <= strobe_d;
            done_q       <= done_d;
            cfg_err_q    <= cfg_err_d;
        end
    end

    assign rx_tdd_en    = rx_en_q;
    assign tx_tdd_en    = tx_en_q;
    assign frame_strobe = strobe_q;
    assign frame_cnt    = frame_cnt_q;
    assign busy         = (state_q != IDLE);
    assign done         = done_q;
    assign cfg_err      = cfg_err_q;

endmodule

// File: tb/tb_adrv9001_tdd_ctrl.sv
// Directed bench for adrv9001_tdd_ctrl: each task drives one scenario and checks
// hand-computed expectations inline; cycle k counts edges after the start edge E0.
module tb_adrv9001_tdd_ctrl;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [31:0] frame_len = '0;
    logic [31:0] rx_on = '0;
    logic [31:0] rx_off = '0;
    logic [31:0] tx_on = '0;
    logic [31:0] tx_off = '0;
    logic [15:0] num_frames = '0;
    logic        rx_tdd_en;
    logic        tx_tdd_en;
    logic        frame_strobe;
    logic [15:0] frame_cnt;
    logic        busy;
    logic        done;
    logic        cfg_err;

    int total = 0;
    int bad = 0;

    adrv9001_tdd_ctrl #(.CNT_WIDTH(32), .FRM_WIDTH(16)) dut (
        .clk(clk), .rstn(rstn), .start(start), .stop(stop),
        .frame_len(frame_len), .rx_on(rx_on), .rx_off(rx_off),
        .tx_on(tx_on), .tx_off(tx_off), .num_frames(num_frames),
        .rx_tdd_en(rx_tdd_en), .tx_tdd_en(tx_tdd_en), .frame_strobe(frame_strobe),
        .frame_cnt(frame_cnt), .busy(busy), .done(done), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cfg(input int len, input int ron, input int roff,
                           input int ton, input int toff, input int nf);
        frame_len  = 32'(len);
        rx_on      = 32'(ron);
        rx_off     = 32'(roff);
        tx_on      = 32'(ton);
        tx_off     = 32'(toff);
        num_frames = 16'(nf);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cycle();
        start = 1'b0;
    endtask

    // Runs n edges, optionally pulsing stop before edge stop_at, and tallies outputs.
    task automatic run_frames(input int n, input int stop_at,
                              output int rx_c, output int tx_c, output int strb_c,
                              output int done_c, output int done_at,
                              output int rx_first, output int busy_last);
        rx_c = 0; tx_c = 0; strb_c = 0; done_c = 0; done_at = 0;
        rx_first = 0; busy_last = 0;
        for (int k = 1; k <= n; k++) begin
            stop = (k == stop_at);
            cycle();
            stop = 1'b0;
            if (rx_tdd_en === 1'b1) begin
                rx_c++;
                if (rx_first == 0) rx_first = k;
            end
            if (tx_tdd_en === 1'b1) tx_c++;
            if (frame_strobe === 1'b1) strb_c++;
            if (done === 1'b1) begin
                done_c++;
                done_at = k;
            end
            if (busy === 1'b1) busy_last = k;
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        cycle();
        cycle();
        total++; if ({rx_tdd_en, tx_tdd_en, frame_strobe, busy, done, cfg_err} !== 6'b0) begin bad++; $display("FAIL reset_flags got=%b exp=000000", {rx_tdd_en, tx_tdd_en, frame_strobe, busy, done, cfg_err}); end
        total++; if (frame_cnt !== 16'd0) begin bad++; $display("FAIL reset_frame_cnt got=%0d exp=0", frame_cnt); end
        rstn = 1'b1;
        cycle();
    endtask

    task automatic test_nominal();
        int rx_c, tx_c, strb_c, done_c, done_at, rx_first, busy_last;
        set_cfg(10, 1, 4, 5, 9, 3);
        pulse_start();
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL nom_busy_after_start got=%b exp=1", busy); end
        run_frames(30, 0, rx_c, tx_c, strb_c, done_c, done_at, rx_first, busy_last);
        total++; if (rx_c !== 9) begin bad++; $display("FAIL nom_rx_cycles got=%0d exp=9", rx_c); end
        total++; if (tx_c !== 12) begin bad++; $display("FAIL nom_tx_cycles got=%0d exp=12", tx_c); end
        total++; if (strb_c !== 3) begin bad++; $display("FAIL nom_strobes got=%0d exp=3", strb_c); end
        total++; if (done_c !== 1 || done_at !== 30) begin bad++; $display("FAIL nom_done got=%0d@%0d exp=1@30", done_c, done_at); end
        total++; if (rx_first !== 2) begin bad++; $display("FAIL nom_rx_first got=%0d exp=2", rx_first); end
        total++; if (busy_last !== 29) begin bad++; $display("FAIL nom_busy_last got=%0d exp=29", busy_last); end
        total++; if (frame_cnt !== 16'd3) begin bad++; $display("FAIL nom_frame_cnt got=%0d exp=3", frame_cnt); end
        total++; if ({rx_tdd_en, tx_tdd_en} !== 2'b00) begin bad++; $display("FAIL nom_en_at_end got=%b exp=00", {rx_tdd_en, tx_tdd_en}); end
    endtask

    task automatic test_infinite_stop();
        int rx_c, tx_c, strb_c, done_c, done_at, rx_first, busy_last;
        set_cfg(8, 0, 3, 4, 8, 0);
        pulse_start();
        // cnt is 2 of the fifth frame after E34, so stop is sampled at E35
        run_frames(40, 35, rx_c, tx_c, strb_c, done_c, done_at, rx_first, busy_last);
        total++; if (done_c !== 1 || done_at !== 40) begin bad++; $display("FAIL inf_done got=%0d@%0d exp=1@40", done_c, done_at); end
        total++; if (busy_last !== 39 || busy !== 1'b0) begin bad++; $display("FAIL inf_busy got_last=%0d busy=%b exp=39,0", busy_last, busy); end
        total++; if (frame_cnt !== 16'd5) begin bad++; $display("FAIL inf_frame_cnt got=%0d exp=5", frame_cnt); end
        total++; if (rx_c !== 15 || rx_first !== 1) begin bad++; $display("FAIL inf_rx got=%0d first=%0d exp=15,1", rx_c, rx_first); end
        total++; if (strb_c !== 5) begin bad++; $display("FAIL inf_strobes got=%0d exp=5", strb_c); end
    endtask

    task automatic test_cfg_errors();
        int rx_c, tx_c, strb_c, done_c, done_at, rx_first, busy_last;
        set_cfg(10, 2, 6, 5, 8, 1);
        pulse_start();
        total++; if (cfg_err !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL err_overlap got_err=%b busy=%b exp=1,0", cfg_err, busy); end
        cycle();
        total++; if (busy !== 1'b0 || cfg_err !== 1'b1) begin bad++; $display("FAIL err_overlap_hold got_busy=%b err=%b exp=0,1", busy, cfg_err); end
        set_cfg(4, 0, 1, 2, 4, 1);
        pulse_start();
        total++; if (cfg_err !== 1'b0 || busy !== 1'b1 || frame_cnt !== 16'd0) begin bad++; $display("FAIL err_clear got_err=%b busy=%b fc=%0d exp=0,1,0", cfg_err, busy, frame_cnt); end
        run_frames(4, 0, rx_c, tx_c, strb_c, done_c, done_at, rx_first, busy_last);
        total++; if (done_at !== 4 || frame_cnt !== 16'd1 || rx_c !== 1) begin bad++; $display("FAIL err_valid_run got_done=%0d fc=%0d rx=%0d exp=4,1,1", done_at, frame_cnt, rx_c); end
        set_cfg(1, 0, 0, 0, 0, 1);
        pulse_start();
        total++; if (cfg_err !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL err_len1 got_err=%b busy=%b exp=1,0", cfg_err, busy); end
        set_cfg(10, 3, 11, 0, 0, 1);
        cycle();
        set_cfg(4, 0, 1, 2, 4, 1);
        pulse_start();
        total++; if (cfg_err !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL err_clear2 got_err=%b busy=%b exp=0,1", cfg_err, busy); end
        run_frames(4, 0, rx_c, tx_c, strb_c, done_c, done_at, rx_first, busy_last);
        set_cfg(10, 3, 11, 0, 0, 1);
        pulse_start();
        total++; if (cfg_err !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL err_rx_off_gt_len got_err=%b busy=%b exp=1,0", cfg_err, busy); end
    endtask

    task automatic test_simul_stop();
        int rx_c, tx_c, strb_c, done_c, done_at, rx_first, busy_last;
        set_cfg(6, 0, 2, 3, 6, 2);
        pulse_start();
        run_frames(12, 12, rx_c, tx_c, strb_c, done_c, done_at, rx_first, busy_last);
        total++; if (done_c !== 1 || done_at !== 12) begin bad++; $display("FAIL sim_done got=%0d@%0d exp=1@12", done_c, done_at); end
        total++; if (busy !== 1'b0 || {rx_tdd_en, tx_tdd_en} !== 2'b00 || frame_cnt !== 16'd2) begin bad++; $display("FAIL sim_end got_busy=%b en=%b fc=%0d exp=0,00,2", busy, {rx_tdd_en, tx_tdd_en}, frame_cnt); end
        run_frames(3, 0, rx_c, tx_c, strb_c, done_c, done_at, rx_first, busy_last);
        total++; if (done_c !== 0 || busy_last !== 0) begin bad++; $display("FAIL sim_no_stopping got_done=%0d busy_last=%0d exp=0,0", done_c, busy_last); end
    endtask

    task automatic test_back_to_back();
        int rx_c, tx_c, strb_c, done_c, done_at, rx_first, busy_last;
        set_cfg(4, 0, 2, 2, 4, 1);
        pulse_start();
        run_frames(4, 0, rx_c, tx_c, strb_c, done_c, done_at, rx_first, busy_last);
        total++; if (done !== 1'b1 || frame_cnt !== 16'd1) begin bad++; $display("FAIL b2b_first got_done=%b fc=%0d exp=1,1", done, frame_cnt); end
        pulse_start();
        total++; if (busy !== 1'b1 || frame_cnt !== 16'd0) begin bad++; $display("FAIL b2b_restart got_busy=%b fc=%0d exp=1,0", busy, frame_cnt); end
        run_frames(4, 0, rx_c, tx_c, strb_c, done_c, done_at, rx_first, busy_last);
        total++; if (done_at !== 4 || rx_c !== 2 || frame_cnt !== 16'd1) begin bad++; $display("FAIL b2b_second got_done=%0d rx=%0d fc=%0d exp=4,2,1", done_at, rx_c, frame_cnt); end
    endtask

    task automatic test_reset_mid();
        int rx_c, tx_c, strb_c, done_c, done_at, rx_first, busy_last;
        set_cfg(10, 1, 6, 7, 9, 0);
        pulse_start();
        run_frames(3, 0, rx_c, tx_c, strb_c, done_c, done_at, rx_first, busy_last);
        total++; if (rx_tdd_en !== 1'b1 || rx_first !== 2) begin bad++; $display("FAIL rstm_pre got_rx=%b first=%0d exp=1,2", rx_tdd_en, rx_first); end
        rstn = 1'b0;
        cycle();
        total++; if ({rx_tdd_en, tx_tdd_en, frame_strobe, busy, done, cfg_err} !== 6'b0 || frame_cnt !== 16'd0) begin bad++; $display("FAIL rstm_outputs got=%b fc=%0d exp=000000,0", {rx_tdd_en, tx_tdd_en, frame_strobe, busy, done, cfg_err}, frame_cnt); end
        rstn = 1'b1;
        cycle();
        set_cfg(4, 0, 2, 2, 4, 1);
        pulse_start();
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL rstm_restart got=%b exp=1", busy); end
        run_frames(4, 0, rx_c, tx_c, strb_c, done_c, done_at, rx_first, busy_last);
        total++; if (done_at !== 4 || rx_c !== 2 || frame_cnt !== 16'd1) begin bad++; $display("FAIL rstm_run got_done=%0d rx=%0d fc=%0d exp=4,2,1", done_at, rx_c, frame_cnt); end
    endtask

    task automatic test_shadow_windows();
        int rx_c, tx_c, strb_c, done_c, done_at, rx_first, busy_last;
        set_cfg(10, 1, 4, 5, 9, 2);
        pulse_start();
        set_cfg(3, 0, 9, 0, 0, 1);
        start = 1'b1;
        run_frames(20, 0, rx_c, tx_c, strb_c, done_c, done_at, rx_first, busy_last);
        start = 1'b0;
        total++; if (rx_c !== 6 || tx_c !== 8) begin bad++; $display("FAIL shd_enables got_rx=%0d tx=%0d exp=6,8", rx_c, tx_c); end
        total++; if (done_at !== 20 || strb_c !== 2 || frame_cnt !== 16'd2) begin bad++; $display("FAIL shd_sequence got_done=%0d strb=%0d fc=%0d exp=20,2,2", done_at, strb_c, frame_cnt); end
        set_cfg(6, 4, 4, 0, 2, 2);
        pulse_start();
        run_frames(12, 0, rx_c, tx_c, strb_c, done_c, done_at, rx_first, busy_last);
        total++; if (rx_c !== 0 || tx_c !== 4 || done_at !== 12) begin bad++; $display("FAIL empty_rx got_rx=%0d tx=%0d done=%0d exp=0,4,12", rx_c, tx_c, done_at); end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_infinite_stop();
        test_cfg_errors();
        test_simul_stop();
        test_back_to_back();
        test_reset_mid();
        test_shadow_windows();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
